// File: rtl/ddr_burst_arbiter_if.sv
// Command/datapath bundle between the burst arbiter and the DDR controller.
// The arbiter drives the command and grant lines; the controller side
// answers with cmd_ready and the end-of-burst pulse.
interface ddr_burst_arbiter_if #(
  parameter int ADDR_WIDTH = 28
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic                  wr_grant;
  logic                  rd_grant;
  logic                  burst_done;

  modport master (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_len,
    output wr_grant,
    output rd_grant,
    input  cmd_ready,
    input  burst_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_len,
    input  wr_grant,
    input  rd_grant,
    output cmd_ready,
    output burst_done
  );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// Burst scheduler sharing one DDR command port between a write requester
// (user-data FIFO draining into DDR) and a read requester (readback FIFO).
// The DDR region is a circular buffer of NUM_BURSTS bursts with separate
// write/read burst pointers and a fill count. One burst is in flight at a
// time: IDLE picks a direction, CMD presents the command until accepted,
// DATA holds the grant until the datapath pulses burst_done.
module ddr_burst_arbiter #(
  parameter int                    ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    BURST_LEN  = 16,
  parameter int                    BEAT_BYTES = 32,
  parameter int                    NUM_BURSTS = 256
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         ddrc_init_done,
  input  logic                         wr_req,
  input  logic                         rd_req,
  ddr_burst_arbiter_if.master          cmd_bus,
  output logic [$clog2(NUM_BURSTS):0] fill_cnt,
  output logic                         busy
);

  localparam int PTR_W       = $clog2(NUM_BURSTS);
  localparam int CNT_W       = PTR_W + 1;
  localparam int BURST_SHIFT = $clog2(BURST_LEN * BEAT_BYTES);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BURSTS);

  // Direction encoding: index 0 = read requester, index 1 = write requester.
  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_dir;
  logic                  w_dir_next;
  logic                  r_last_dir;
  logic                  w_last_dir_next;
  logic [CNT_W-1:0]      r_fill_cnt;
  logic [CNT_W-1:0]      w_fill_next;
  logic                  r_cmd_valid;
  logic                  w_cmd_valid_next;
  logic                  r_cmd_write;
  logic                  w_cmd_write_next;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [ADDR_WIDTH-1:0] w_cmd_addr_next;
  logic                  r_wr_grant;
  logic                  w_wr_grant_next;
  logic                  r_rd_grant;
  logic                  w_rd_grant_next;
  logic                  r_busy;
  logic                  w_busy_next;

  logic [1:0]            w_ok;
  logic [PTR_W-1:0]      r_ptr      [2];
  logic [ADDR_WIDTH-1:0] w_ptr_addr [2];
  logic                  w_done;
  logic                  w_pick;

  // burst_done only means something while a burst is actually granted.
  assign w_done = (r_state == ST_DATA) && cmd_bus.burst_done;

  // Per-direction eligibility, burst address and burst pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      if (gi == 1) begin : g_wr
        assign w_ok[gi] = wr_req && (r_fill_cnt != FULL_CNT);
      end else begin : g_rd
        assign w_ok[gi] = rd_req && (r_fill_cnt != '0);
      end

      // Byte address of the burst slot this pointer currently names;
      // anything above ADDR_WIDTH falls off.
      assign w_ptr_addr[gi] = BASE_ADDR + (ADDR_WIDTH'(r_ptr[gi]) << BURST_SHIFT);

      // Pointer steps to the next slot when its own burst completes; the
      // power-of-two depth makes the wrap to 0 free.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_ptr[gi] <= '0;
        end else if (w_done && (r_dir == 1'(gi))) begin
          r_ptr[gi] <= r_ptr[gi] + PTR_W'(1);
        end
      end
    end
  endgenerate

  // Next-state and next-output logic for the IDLE/CMD/DATA sequence.
  always_comb begin
    w_state_next     = r_state;
    w_dir_next       = r_dir;
    w_last_dir_next  = r_last_dir;
    w_fill_next      = r_fill_cnt;
    w_cmd_valid_next = r_cmd_valid;
    w_cmd_write_next = r_cmd_write;
    w_cmd_addr_next  = r_cmd_addr;
    w_wr_grant_next  = r_wr_grant;
    w_rd_grant_next  = r_rd_grant;
    w_busy_next      = r_busy;
    w_pick           = DIR_RD;

    case (r_state)
      ST_IDLE: begin
        // Contested: alternate away from the last served direction.
        // Uncontested: whichever side is eligible.
        w_pick = (&w_ok) ? ~r_last_dir : w_ok[1];
        if (ddrc_init_done && (|w_ok)) begin
          w_state_next     = ST_CMD;
          w_dir_next       = w_pick;
          w_cmd_valid_next = 1'b1;
          w_cmd_write_next = w_pick;
          w_cmd_addr_next  = w_ptr_addr[w_pick];
          w_busy_next      = 1'b1;
        end
      end

      ST_CMD: begin
        // Command, direction and address stay frozen until accepted.
        if (cmd_bus.cmd_ready) begin
          w_state_next     = ST_DATA;
          w_cmd_valid_next = 1'b0;
          w_last_dir_next  = r_dir;
          w_wr_grant_next  = (r_dir == DIR_WR);
          w_rd_grant_next  = (r_dir == DIR_RD);
        end
      end

      ST_DATA: begin
        // Only one burst is outstanding, so fill count moves by one at most.
        if (cmd_bus.burst_done) begin
          w_state_next    = ST_IDLE;
          w_wr_grant_next = 1'b0;
          w_rd_grant_next = 1'b0;
          w_busy_next     = 1'b0;
          if (r_dir == DIR_WR) begin
            w_fill_next = r_fill_cnt + CNT_W'(1);
          end else begin
            w_fill_next = r_fill_cnt - CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_cmd_valid_next = 1'b0;
        w_wr_grant_next  = 1'b0;
        w_rd_grant_next  = 1'b0;
        w_busy_next      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight burst.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_RD;
      r_last_dir  <= DIR_RD;
      r_fill_cnt  <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= BASE_ADDR;
      r_wr_grant  <= 1'b0;
      r_rd_grant  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dir       <= w_dir_next;
      r_last_dir  <= w_last_dir_next;
      r_fill_cnt  <= w_fill_next;
      r_cmd_valid <= w_cmd_valid_next;
      r_cmd_write <= w_cmd_write_next;
      r_cmd_addr  <= w_cmd_addr_next;
      r_wr_grant  <= w_wr_grant_next;
      r_rd_grant  <= w_rd_grant_next;
      r_busy      <= w_busy_next;
    end
  end

  assign cmd_bus.cmd_valid = r_cmd_valid;
  assign cmd_bus.cmd_write = r_cmd_write;
  assign cmd_bus.cmd_addr  = r_cmd_addr;
  assign cmd_bus.cmd_len   = 8'(BURST_LEN - 1);
  assign cmd_bus.wr_grant  = r_wr_grant;
  assign cmd_bus.rd_grant  = r_rd_grant;
  assign fill_cnt          = r_fill_cnt;
  assign busy              = r_busy;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Bench for ddr_burst_arbiter: directed scenarios, a transaction-level
// reference model checked every cycle, and literal expectations.
module tb_ddr_burst_arbiter;

  localparam int              AW   = 28;
  localparam logic [AW-1:0]   BASE = 28'h0A00000;
  localparam int              BL   = 16;
  localparam int              BB   = 32;
  localparam int              NB   = 256;
  localparam int              BSZ  = BL * BB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic       init_done = 1'b0;
  logic       wr_req    = 1'b0;
  logic       rd_req    = 1'b0;
  logic [8:0] fill_cnt;
  logic       busy;

  ddr_burst_arbiter_if #(.ADDR_WIDTH(AW)) bus();

  ddr_burst_arbiter #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .BURST_LEN  (BL),
    .BEAT_BYTES (BB),
    .NUM_BURSTS (NB)
  ) dut (
    .sys_clk        (clk),
    .sys_rst_n      (rst_n),
    .ddrc_init_done (init_done),
    .wr_req         (wr_req),
    .rd_req         (rd_req),
    .cmd_bus        (bus),
    .fill_cnt       (fill_cnt),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- datapath responder ----------------
  logic done_pulse = 1'b0;
  logic stray_done = 1'b0;
  bit   auto_done  = 1'b1;
  int   gcnt       = 0;

  assign bus.burst_done = done_pulse | stray_done;

  // burst_done is seen at the 4th clock edge after the grant rises.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      done_pulse = 1'b0;
      if (auto_done && (bus.wr_grant || bus.rd_grant)) begin
        gcnt++;
        if (gcnt == 4) done_pulse = 1'b1;
      end else begin
        gcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  int            m_phase   = 0;    // 0 waiting, 1 command offered, 2 burst running
  bit            m_dir     = 0;    // 1 = write
  bit            m_last_wr = 0;
  int            m_wptr    = 0;
  int            m_rptr    = 0;
  int            m_fill    = 0;
  bit            m_cmd_wr  = 0;
  logic [AW-1:0] m_addr    = BASE;
  bit            mw_ok, mr_ok;
  longint        m_byte;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_dir = 0; m_last_wr = 0; m_wptr = 0; m_rptr = 0;
      m_fill = 0; m_cmd_wr = 0; m_addr = BASE;
    end else if (m_phase == 0) begin
      mw_ok = wr_req && (m_fill < NB);
      mr_ok = rd_req && (m_fill > 0);
      if (init_done && (mw_ok || mr_ok)) begin
        m_dir    = (mw_ok && mr_ok) ? !m_last_wr : mw_ok;
        m_byte   = longint'(BASE) + longint'(m_dir ? m_wptr : m_rptr) * BSZ;
        m_addr   = m_byte[AW-1:0];
        m_cmd_wr = m_dir;
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.cmd_ready) begin
        m_phase   = 2;
        m_last_wr = m_dir;
      end
    end else begin
      if (bus.burst_done) begin
        if (m_dir) begin
          m_wptr = (m_wptr + 1) % NB;
          m_fill = m_fill + 1;
        end else begin
          m_rptr = (m_rptr + 1) % NB;
          m_fill = m_fill - 1;
        end
        m_phase = 0;
      end
    end
  end

  // ---------------- compare + transaction log ----------------
  bit            hs_w [$];
  logic [AW-1:0] hs_a [$];
  int            hs_f [$];

  always @(negedge clk) begin
    check("cmd_valid", bus.cmd_valid, m_phase == 1);
    check("cmd_write", bus.cmd_write, m_cmd_wr);
    check("cmd_addr",  bus.cmd_addr,  m_addr);
    check("wr_grant",  bus.wr_grant,  (m_phase == 2) && m_dir);
    check("rd_grant",  bus.rd_grant,  (m_phase == 2) && !m_dir);
    check("fill_cnt",  fill_cnt,      m_fill);
    check("busy",      busy,          m_phase != 0);
    if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
      hs_w.push_back(bus.cmd_write);
      hs_a.push_back(bus.cmd_addr);
      hs_f.push_back(int'(fill_cnt));
      $display("txn %0d %s addr=%h fill=%0d", hs_w.size() - 1,
               bus.cmd_write ? "WR" : "RD", bus.cmd_addr, fill_cnt);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fill(input int val, input int budget, input string name);
    int k = 0;
    while (fill_cnt != val && k < budget) begin
      tick(1);
      k++;
    end
    check(name, fill_cnt, val);
  endtask

  task automatic wait_hs(input int n, input int budget, input string name);
    int k = 0;
    while (hs_w.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, hs_w.size() >= n, 1);
  endtask

  // which: 0 cmd_valid, 1 wr_grant, 2 not busy
  task automatic wait_sig(input int which, input int budget, input string name);
    int   k = 0;
    logic s;
    s = (which == 0) ? bus.cmd_valid : (which == 1) ? bus.wr_grant : !busy;
    while (!s && k < budget) begin
      tick(1);
      k++;
      s = (which == 0) ? bus.cmd_valid : (which == 1) ? bus.wr_grant : !busy;
    end
    check(name, s, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, bus.cmd_valid, 0);
    check({tag, "_cmd_write"}, bus.cmd_write, 0);
    check({tag, "_cmd_addr"},  bus.cmd_addr,  BASE);
    check({tag, "_wr_grant"},  bus.wr_grant,  0);
    check({tag, "_rd_grant"},  bus.rd_grant,  0);
    check({tag, "_fill_cnt"},  fill_cnt,      0);
    check({tag, "_busy"},      busy,          0);
    check({tag, "_cmd_len"},   bus.cmd_len,   BL - 1);
  endtask

  // ---------------- directed scenarios ----------------
  int n0;
  int nw;
  int nr;

  initial begin
    bus.cmd_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_reset_outputs("reset");

    // Controller not ready: a pending write must not issue.
    wr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("noinit_cmd_valid", bus.cmd_valid, 0);
    end
    check("noinit_busy", busy, 0);
    init_done = 1'b1;
    tick(1);
    check("first_cmd_valid", bus.cmd_valid, 1);
    check("first_cmd_write", bus.cmd_write, 1);
    check("first_cmd_addr",  bus.cmd_addr,  BASE);

    // Backpressure: command held steady, grant waits for the handshake.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_cmd_valid", bus.cmd_valid, 1);
      check("bp_cmd_write", bus.cmd_write, 1);
      check("bp_cmd_addr",  bus.cmd_addr,  BASE);
      check("bp_wr_grant",  bus.wr_grant,  0);
    end
    bus.cmd_ready = 1'b1;
    tick(1);
    check("hs_cmd_valid", bus.cmd_valid, 0);
    check("hs_wr_grant",  bus.wr_grant,  1);
    wait_fill(1, 20, "first_burst_fill");

    // Write-only fill to capacity.
    wait_fill(256, 3000, "fill_to_full");
    n0 = hs_w.size();
    tick(20);
    check("full_no_more_cmds", hs_w.size(), n0);
    check("full_cmd_valid",    bus.cmd_valid, 0);
    check("full_fill",         fill_cnt, 256);
    check("full_write_count",  n0, 256);
    check("addr_step_1",       hs_a[1],   BASE + 28'd512);
    check("addr_step_255",     hs_a[255], BASE + 28'h1FE00);

    // Wrap: reads start from slot 0, next write wraps to slot 0.
    rd_req = 1'b1;
    wait_hs(n0 + 6, 200, "wrap_cmds");
    check("wrap_r0_dir",  hs_w[n0],     0);
    check("wrap_r0_addr", hs_a[n0],     BASE);
    check("wrap_w257_dir",  hs_w[n0 + 1], 1);
    check("wrap_w257_addr", hs_a[n0 + 1], BASE);
    check("wrap_r1_addr", hs_a[n0 + 2], BASE + 28'd512);
    check("wrap_w258_addr", hs_a[n0 + 3], BASE + 28'd512);
    wr_req = 1'b0;
    wait_fill(0, 4000, "drain_to_empty");
    n0 = hs_w.size();
    tick(20);
    check("empty_no_more_cmds", hs_w.size(), n0);
    check("empty_busy", busy, 0);
    nw = 0;
    nr = 0;
    foreach (hs_w[i]) begin
      if (hs_w[i]) nw++;
      else nr++;
    end
    check("reads_equal_writes", nr, nw);

    // Contention at fill 3 with last served = read.
    rd_req = 1'b0;
    wr_req = 1'b1;
    wait_fill(4, 100, "cont_prefill");
    wr_req = 1'b0;
    rd_req = 1'b1;
    wait_fill(3, 50, "cont_one_read");
    wr_req = 1'b1;
    n0 = hs_w.size();
    wait_hs(n0 + 4, 100, "cont_cmds");
    check("cont_dir0",  hs_w[n0],     1);
    check("cont_dir1",  hs_w[n0 + 1], 0);
    check("cont_dir2",  hs_w[n0 + 2], 1);
    check("cont_dir3",  hs_w[n0 + 3], 0);
    check("cont_fill0", hs_f[n0],     3);
    check("cont_fill1", hs_f[n0 + 1], 4);
    check("cont_fill2", hs_f[n0 + 2], 3);
    check("cont_fill3", hs_f[n0 + 3], 4);
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_sig(2, 50, "cont_idle");

    // Reset in the middle of a write burst.
    auto_done = 1'b0;
    wr_req    = 1'b1;
    wait_sig(1, 20, "rst_wait_grant");
    wr_req = 1'b0;
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    stray_done = 1'b1;
    tick(1);
    stray_done = 1'b0;
    tick(2);
    check("stray_busy", busy, 0);
    check("stray_fill", fill_cnt, 0);
    check("stray_cmd_valid", bus.cmd_valid, 0);

    // Pointers restart from slot 0 in both directions.
    auto_done = 1'b1;
    wr_req    = 1'b1;
    wait_sig(0, 20, "post_rst_wr_cmd");
    wr_req = 1'b0;
    check("post_rst_wr_write", bus.cmd_write, 1);
    check("post_rst_wr_addr",  bus.cmd_addr,  BASE);
    wait_fill(1, 30, "post_rst_wr_fill");
    rd_req = 1'b1;
    wait_sig(0, 20, "post_rst_rd_cmd");
    rd_req = 1'b0;
    check("post_rst_rd_write", bus.cmd_write, 0);
    check("post_rst_rd_addr",  bus.cmd_addr,  BASE);
    wait_fill(0, 30, "post_rst_rd_fill");
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_burst_arbiter.md
# ddr_burst_arbiter

Burst scheduler that shares the single DDR controller command port between a write requester and a read requester. The write requester is the user-data FIFO that drains into DDR; the read requester is the readback/display FIFO. It maintains a circular burst buffer in DDR with independent write/read burst pointers and a fill count. It round-robins grants, issues one burst command at a time, and holds the grant until the datapath reports burst completion.

## Interface
Parameters:
- ADDR_WIDTH, 28, DDR byte-address width
- BASE_ADDR, 0, byte address of burst buffer start
- BURST_LEN, 16, beats per burst (power of 2, 1..256)
- BEAT_BYTES, 32, bytes per beat (power of 2)
- NUM_BURSTS, 256, buffer capacity in bursts (power of 2, ≥2)

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- ddrc_init_done  in  1  DDR controller ready; no new command unless high
- wr_req  in  1  write FIFO holds ≥BURST_LEN words
- rd_req  in  1  read FIFO has ≥BURST_LEN free words
- cmd_valid  out  1  command request to DDR controller
- cmd_ready  in  1  controller accepts command when cmd_valid && cmd_ready
- cmd_write  out  1  1 = write burst, 0 = read burst
- cmd_addr  out  ADDR_WIDTH  burst byte address
- cmd_len  out  8  BURST_LEN-1, constant
- wr_grant  out  1  write datapath enabled (command accepted through completion)
- rd_grant  out  1  read datapath enabled
- burst_done  in  1  one-cycle pulse: last beat of current burst transferred
- fill_cnt  out  log2(NUM_BURSTS)+1  bursts stored, not yet read
- busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → CMD → DATA → IDLE.
- IDLE:
  - w_ok = wr_req && fill_cnt < NUM_BURSTS; r_ok = rd_req && fill_cnt > 0.
  - If ddrc_init_done and (w_ok or r_ok): register the choice and go to CMD.
  - Only one eligible: choose it. Both eligible: choose opposite of last_dir (round-robin); last_dir resets to read, so the first contested grant goes to write.
- CMD: cmd_valid=1, cmd_write/cmd_addr stable until cmd_valid && cmd_ready. In the acceptance cycle go to DATA; last_dir updates to the served direction.
- DATA: wr_grant or rd_grant high per direction. On burst_done:
  - Advance that direction's pointer modulo NUM_BURSTS.
  - Write: fill_cnt+1; read: fill_cnt−1.
  - Return to IDLE.
- cmd_addr = BASE_ADDR + ptr × BURST_LEN × BEAT_BYTES, truncated to ADDR_WIDTH; ptr is wr_ptr or rd_ptr per direction.
- One burst outstanding at a time, so fill_cnt never sees simultaneous increment and decrement.
- Boundaries:
  - fill_cnt == NUM_BURSTS: writes blocked. fill_cnt == 0: reads blocked.
  - Pointers wrap NUM_BURSTS-1 → 0 silently.
  - burst_done outside DATA is ignored.
  - ddrc_init_done is sampled only in IDLE; falling in CMD/DATA does not abort the transaction.
  - wr_req/rd_req changes after IDLE decision are ignored until next IDLE.
- Reset (any state): state=IDLE, pointers=0, fill_cnt=0, last_dir=read; in-flight burst discarded.

## Timing
- Reset values: cmd_valid=0, cmd_write=0, cmd_addr=BASE_ADDR, wr_grant=0, rd_grant=0, fill_cnt=0, busy=0; cmd_len=BURST_LEN-1 always.
- All outputs registered.
- Request sampled in IDLE at edge N → cmd_valid high from edge N+1.
- cmd_ready high on first cmd_valid cycle → cmd_valid low and grant high from next edge.
- burst_done at edge M → grant low, pointer/fill_cnt updated, busy low after edge M.
- Earliest re-arbitration at M+1. Minimum turnaround: 3 cycles between bursts (IDLE, CMD, ≥1 DATA).
- cmd_valid never deasserts without handshake.

## Test plan
- Reset/idle: hold ddrc_init_done=0, wr_req=1 for 20 cycles → cmd_valid stays 0, busy=0; raise init_done → cmd_valid next cycle, cmd_write=1, cmd_addr=BASE_ADDR.
- Write-only fill: defaults, wr_req=1, cmd_ready=1, burst_done 4 cycles after grant, repeated → addresses step by 512 bytes; after 256 bursts fill_cnt=256 and no further cmd_valid.
- Contention: fill_cnt=3, wr_req=rd_req=1 continuously → commands alternate W,R,W,R starting with W; fill_cnt oscillates 3↔4.
- Wrap: 256 writes then 256 reads interleaved → the 257th write cmd_addr = BASE_ADDR; reads follow the same address sequence; fill_cnt returns to 0 and reads stop.
- Backpressure: cmd_ready low 10 cycles → cmd_valid, cmd_addr, cmd_write held constant; grant asserts only the cycle after the handshake.
- Reset mid-burst: assert sys_rst_n=0 during DATA → all outputs at reset values immediately, pointers 0. A stray burst_done after reset is ignored.
